// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   state_e       : fetch sequencer states
//   fetch_entry_t : one fetch queue entry {pc, instr}
package ifu_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHalt
    } state_e;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Circular fetch queue of DEPTH entries (DEPTH a power of two, >= 2).
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, push_data : write one entry at the tail
//   pop             : drop the head entry (ignored while empty)
//   flush           : discard all entries and rewind both pointers
//   head            : head entry, all zeros while empty
//   count           : number of valid entries
//   full            : count == DEPTH
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & (count_q != '0);
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: the head is gated by count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational instruction
// memory, queues {pc, instr} pairs and hands them to decode.
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   start                       : begin fetching from RESET_PC (IDLE/HALT only)
//   redirect_valid, redirect_pc : taken branch/jump, flushes the queue
//   imem_pc, imem_instr         : instruction memory address / same-cycle data
//   inst_valid, inst_ready      : decode handshake
//   inst_code, inst_pc          : head instruction and its PC (0 when empty)
//   halted                      : high in HALT
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_0020,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    output logic        halted
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          push, pop, flush, full;
    logic [CW-1:0] count;
    fetch_entry_t  head, push_data;

    assign push_data = '{pc: pc_q, instr: imem_instr};
    assign pop       = inst_valid & inst_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        // Redirect overrides everything except IDLE, where fetch has not begun.
        if (redirect_valid && state_q != StIdle) begin
            flush   = 1'b1;
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = StRun;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        pc_d    = RESET_PC;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (pc_q >= PC_LIMIT) begin
                        state_d = StDrain;
                    end else if (!full || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + PC_INC;
                    end
                end
                StDrain: begin
                    if (count == '0 || (count == CW'(1) && pop)) state_d = StHalt;
                end
                StHalt: begin
                    if (start) begin
                        pc_d    = RESET_PC;
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifu_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .count    (count),
        .full     (full)
    );

    assign imem_pc    = pc_q;
    assign inst_valid = (count != '0);
    assign inst_code  = head.instr;
    assign inst_pc    = head.pc;
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl. The stimulus process appends the
// program-order stream each start/redirect should deliver; a negedge monitor
// pops and compares on every decode handshake.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_LIMIT = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_ready = 1'b0;
    logic [31:0] imem_pc, imem_instr, inst_code, inst_pc;
    logic        inst_valid, halted;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h20) return 32'hBAD0_0000 ^ a;
        case (a[4:2])
            3'd0: return 32'h0094_0333;
            3'd1: return 32'h4139_03b3;
            3'd2: return 32'h035a_02b3;
            3'd3: return 32'h017b_4e33;
            3'd4: return 32'h019c_1eb3;
            3'd5: return 32'h01bd_5f33;
            3'd6: return 32'h00d6_7fb3;
            default: return 32'h00f7_68b3;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_pc);

    ifu_fetch_ctrl #(
        .RESET_PC(RESET_PC),
        .PC_LIMIT(PC_LIMIT),
        .DEPTH   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_code     (inst_code),
        .inst_pc       (inst_pc),
        .halted        (halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: a run from p delivers every word from p up to the limit, in order.
    task automatic load_run(input logic [31:0] p);
        for (logic [31:0] a = p; a < PC_LIMIT; a += 32'd4) begin
            exp_t e;
            e.pc   = a;
            e.code = mem_word(a);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; drives one cycle and updates the model afterwards.
    task automatic cycle_drive(input bit do_redir, input logic [31:0] tgt,
                               input bit do_start, input bit rdy);
        bit was_halted;
        was_halted     = halted;
        redirect_valid = do_redir;
        redirect_pc    = tgt;
        start          = do_start;
        inst_ready     = rdy;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        start          = 1'b0;
        if (do_redir && started) begin
            exp_q.delete();
            load_run({tgt[31:2], 2'b00});
        end else if (do_start && (!started || was_halted)) begin
            load_run(RESET_PC);
            started = 1'b1;
        end
    endtask

    task automatic wait_halted(input string name);
        for (int i = 0; i < 40 && !halted; i++) cycle_drive(1'b0, '0, 1'b0, 1'b1);
        check({name, "_halted"}, {63'b0, halted}, 64'd1);
        check({name, "_all_delivered"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL extra_inst: got pc %h code %h, expected nothing", inst_pc,
                             inst_code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("inst", {inst_pc, inst_code}, {e.pc, e.code});
                end
            end else if (!inst_valid) begin
                check("empty_zero", {inst_pc, inst_code}, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check("rst_imem_pc", {32'b0, imem_pc}, {32'b0, RESET_PC});
        check("rst_outputs", {29'b0, inst_valid, halted, 1'b0, inst_code}, 64'h0);
        check("rst_inst_pc", {32'b0, inst_pc}, 64'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full program, decode always ready; first instruction two cycles after start
        cycle_drive(1'b0, '0, 1'b1, 1'b1);
        check("lat_run_not_valid", {63'b0, inst_valid}, 64'd0);
        cycle_drive(1'b0, '0, 1'b0, 1'b1);
        check("lat_first_valid", {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'h0});
        check("lat_first_code", {32'b0, inst_code}, 64'h0094_0333);
        wait_halted("full_run");

        // Stalled decode: exactly two entries queue up
        cycle_drive(1'b0, '0, 1'b1, 1'b0);
        repeat (4) cycle_drive(1'b0, '0, 1'b0, 1'b0);
        check("stall_imem_pc", {32'b0, imem_pc}, 64'h8);
        check("stall_head", {31'b0, inst_valid, inst_pc}, {31'b0, 1'b1, 32'h0});
        wait_halted("stall_release");

        // Redirect to an unaligned target while the queue holds PC 4/8
        cycle_drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cycle_drive(1'b0, '0, 1'b0, 1'b0);
        cycle_drive(1'b0, '0, 1'b0, 1'b1);
        check("pre_redir_head", {32'b0, inst_pc}, 64'h4);
        cycle_drive(1'b1, 32'h0000_0011, 1'b0, 1'b0);
        check("redir_flush", {31'b0, inst_valid, imem_pc}, {31'b0, 1'b0, 32'h10});
        cycle_drive(1'b0, '0, 1'b0, 1'b0);
        check("redir_head", {inst_pc, inst_code}, {32'h10, 32'h019c_1eb3});
        wait_halted("redir_run");

        // Redirect while halted
        cycle_drive(1'b1, 32'h0000_0018, 1'b0, 1'b1);
        check("halt_redir_drop", {63'b0, halted}, 64'd0);
        wait_halted("halt_redir");

        // Reset mid-run with two entries queued
        cycle_drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cycle_drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_outputs", {30'b0, inst_valid, halted, imem_pc}, 64'h0);
        check("midrst_head", {inst_pc, inst_code}, 64'h0);
        exp_q.delete();
        started = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Redirect in IDLE is ignored
        cycle_drive(1'b1, 32'h0000_0010, 1'b0, 1'b1);
        cycle_drive(1'b0, '0, 1'b0, 1'b1);
        check("idle_redir_ignored", {31'b0, inst_valid, imem_pc}, 64'h0);
        cycle_drive(1'b0, '0, 1'b1, 1'b1);
        wait_halted("replay");

        // start in RUN ignored, ready toggling each cycle
        cycle_drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle_drive(1'b0, '0, (i == 3), i[0]);
        wait_halted("toggle");

        // Randomized start/redirect/ready
        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            cycle_drive((r < 5), 32'($urandom_range(0, 32'h2C)), (r == 0 || (r >= 5 && r < 12)),
                        ($urandom_range(0, 3) != 0));
        end
        wait_halted("random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Fetch sequencer for the Instruction Fetch Unit.
- Owns the program counter and drives the address of the combinational instruction memory.
- Captures each returned instruction word, together with its PC, into a small fetch queue.
- Presents queued instructions to decode over a valid/ready handshake; handles start, branch/jump redirect with queue flush, and an end-of-program halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset and on restart.
- PC_LIMIT, 32'h0000_0020, first byte address past the loaded program; fetch stops when pc >= PC_LIMIT (unsigned compare).
- DEPTH, 2, fetch queue entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: begin fetching from RESET_PC (accepted in IDLE and HALT only).
- redirect_valid  in  1  branch/jump taken; flush queue and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.
- imem_pc  out  32  address to instruction memory (= pc register).
- imem_instr  in  32  instruction memory data, valid in the same cycle as imem_pc.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_code  out  32  head instruction word; 0 when empty.
- inst_pc  out  32  head instruction PC; 0 when empty.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE, count=0, rd/wr pointers=0, inst_valid=0, inst_code=0, inst_pc=0, halted=0, imem_pc=RESET_PC.
- States: IDLE, RUN, DRAIN, HALT.
- IDLE: no fetch; start -> RUN next cycle.
- RUN, per cycle:
  - pop = inst_valid & inst_ready.
  - push = (pc < PC_LIMIT) & (count < DEPTH | pop).
  - Push writes {pc, imem_instr}; then pc <= pc + 4 (mod 2^32 wrap, no flag).
  - pc >= PC_LIMIT -> DRAIN, no push.
- DRAIN: no fetch; pops continue; count reaches 0 -> HALT.
- HALT: halted=1; start -> pc=RESET_PC, RUN.
- Queue:
  - Circular buffer; count updates +push, -pop; simultaneous push and pop when full is legal, count unchanged.
  - inst_valid = (count != 0); inst_code/inst_pc driven from the head register (no combinational path from imem_instr to outputs).
- Latency: start at cycle N -> RUN at N+1 -> first push at end of N+1 -> inst_valid at N+2. Steady state with inst_ready=1: one instruction per cycle.
- Redirect (highest priority; valid in RUN, DRAIN, HALT; ignored in IDLE):
  - Queue flushed (count=0, pointers reset); no push that cycle.
  - A pop in the same cycle still counts as consumed.
  - pc <= {redirect_pc[31:2], 2'b00}; state <= RUN; halted drops next cycle.
  - Redirect and start together: redirect wins.
- start in RUN or DRAIN: ignored.
- inst_ready while empty: no effect.
- Reset mid-run: immediate return to reset values; queue contents discarded.

Decomposition:
- Shared package ifu_pkg:
  - state enum (IDLE/RUN/DRAIN/HALT).
  - INST_W=32, PC_INC=4.
  - Fetch-entry struct {pc, instr}.
- Sub-module ifu_fetch_fifo: parametric DEPTH circular buffer with push/pop/flush/count; the top holds the PC and FSM.

Test Plan:
- Reset then start, inst_ready=1, memory preloaded 00940333, 413903b3, 035a02b3, 017b4e33, 019c1eb3, 01bd5f33, 00d67fb3, 00f768b3 -> inst_valid from cycle 2; pc/code pairs 0/00940333 … 1C/00f768b3 on consecutive cycles; halted=1 after the 8th pop.
- inst_ready=0 after start -> exactly 2 entries queued (PC 0, 4); imem_pc holds 8. Release inst_ready -> all 8 in order, none lost or duplicated.
- Redirect to 32'h0000_0011 while queue holds PC 4/8 -> queue empties; next inst_pc=0x10 with code 019c1eb3; then 0x14, 0x18, 0x1C.
- Redirect to 0x18 while halted -> halted falls; instructions 00d67fb3 and 00f768b3 delivered; halted again.
- Reset asserted mid-run with 2 entries queued -> inst_valid=0, imem_pc=0, state IDLE immediately; start replays from PC 0.
- start while RUN, inst_ready toggling every cycle -> ignored; sequence uninterrupted; full queue with simultaneous push/pop keeps count=2.
